// File: rtl/mips_run_pkg.sv
// Shared types and trace-entry layout for the mips run controller.
package mips_run_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRstHold,
        StRun,
        StDone
    } run_state_e;

    localparam int unsigned TRACE_W         = 69;
    localparam int unsigned TRACE_WDATA_LSB = 0;
    localparam int unsigned TRACE_WADDR_LSB = 32;
    localparam int unsigned TRACE_PC_LSB    = 37;

    function automatic logic [TRACE_W-1:0] pack_trace(input logic [31:0] pc,
                                                      input logic [4:0]  waddr,
                                                      input logic [31:0] wdata);
        logic [TRACE_W-1:0] e;
        e = '0;
        e[TRACE_PC_LSB +: 32]    = pc;
        e[TRACE_WADDR_LSB +: 5]  = waddr;
        e[TRACE_WDATA_LSB +: 32] = wdata;
        return e;
    endfunction

endpackage

// File: rtl/run_trace_buf.sv
// Circular writeback trace: keeps the newest DEPTH entries, read back oldest-relative
// through a one-cycle registered port.
module run_trace_buf
    import mips_run_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       we_i,
    input  logic [TRACE_W-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       rd_valid_o,
    output logic [TRACE_W-1:0]         rd_data_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [TRACE_W-1:0] mem_q [DEPTH];
    logic [IdxW-1:0]    wr_ptr_q;
    logic [IdxW:0]      count_q;
    logic               rd_valid_q;
    logic [TRACE_W-1:0] rd_data_q;

    logic [IdxW-1:0]    oldest;
    logic [IdxW-1:0]    rd_addr;
    logic               rd_hit;

    // Count's low bits are zero when full, so this yields wr_ptr (full) or 0 (filling).
    assign oldest  = wr_ptr_q - count_q[IdxW-1:0];
    assign rd_addr = oldest + rd_idx_i;
    assign rd_hit  = {1'b0, rd_idx_i} < count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (clear_i) begin
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else if (we_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (count_q != (IdxW + 1)'(DEPTH)) begin
                    count_q <= count_q + 1'b1;
                end
            end
            rd_valid_q <= rd_hit;
            rd_data_q  <= rd_hit ? mem_q[rd_addr] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && we_i && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign count_o    = count_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller beside the mips core: reset sequencing, cycle/retire counting,
// end-of-program and timeout detection, and a writeback trace for post-run dump.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned TIMEOUT     = 100000,
    parameter logic [31:0] HALT_PC     = 32'h0000_3ffc,
    parameter int unsigned HALT_REPEAT = 4,
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic                           retire_valid_i,
    input  logic [31:0]                    retire_pc_i,
    input  logic                           reg_we_i,
    input  logic [4:0]                     reg_waddr_i,
    input  logic [31:0]                    reg_wdata_i,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx_i,
    output logic                           core_reset_o,
    output logic                           running_o,
    output logic                           done_o,
    output logic                           halted_o,
    output logic                           timed_out_o,
    output logic [CNT_W-1:0]               cycle_cnt_o,
    output logic [CNT_W-1:0]               retire_cnt_o,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count_o,
    output logic                           trace_rd_valid_o,
    output logic [TRACE_W-1:0]             trace_rd_data_o
);

    localparam int unsigned HoldW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned RepW  = $clog2(HALT_REPEAT + 1);
    localparam logic [HoldW-1:0] HoldLast    = HoldW'(RST_CYCLES - 1);
    localparam logic [RepW-1:0]  RepTarget   = RepW'(HALT_REPEAT);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

    run_state_e       state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic             halted_q, halted_d;
    logic             timed_out_q, timed_out_d;
    logic [31:0]      prev_pc_q, prev_pc_d;
    logic             prev_valid_q, prev_valid_d;
    logic [RepW-1:0]  rep_q, rep_d;

    logic             start_run;
    logic [RepW-1:0]  rep_next;
    logic             halt_hit;
    logic             timeout_hit;
    logic             trace_we;

    // Run length of identical retired PCs; idle cycles leave it untouched.
    always_comb begin
        rep_next = RepW'(1);
        if (prev_valid_q && retire_pc_i == prev_pc_q) begin
            rep_next = (rep_q == '1) ? rep_q : rep_q + 1'b1;
        end
    end

    assign halt_hit    = retire_valid_i && (retire_pc_i == HALT_PC || rep_next >= RepTarget);
    assign timeout_hit = (TIMEOUT != 0) && (cycle_q == TimeoutLast);

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        cycle_d      = cycle_q;
        retire_d     = retire_q;
        halted_d     = halted_q;
        timed_out_d  = timed_out_q;
        prev_pc_d    = prev_pc_q;
        prev_valid_d = prev_valid_q;
        rep_d        = rep_q;
        start_run    = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d      = StRstHold;
                    start_run    = 1'b1;
                    hold_d       = '0;
                    cycle_d      = '0;
                    retire_d     = '0;
                    halted_d     = 1'b0;
                    timed_out_d  = 1'b0;
                    prev_valid_d = 1'b0;
                    rep_d        = '0;
                end
            end
            StRstHold: begin
                if (hold_q == HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StRun: begin
                if (cycle_q != '1) begin
                    cycle_d = cycle_q + 1'b1;
                end
                if (retire_valid_i) begin
                    if (retire_q != '1) begin
                        retire_d = retire_q + 1'b1;
                    end
                    prev_pc_d    = retire_pc_i;
                    prev_valid_d = 1'b1;
                    rep_d        = rep_next;
                end
                if (halt_hit) begin
                    state_d  = StDone;
                    halted_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d     = StDone;
                    timed_out_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            cycle_q      <= '0;
            retire_q     <= '0;
            halted_q     <= 1'b0;
            timed_out_q  <= 1'b0;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            rep_q        <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cycle_q      <= cycle_d;
            retire_q     <= retire_d;
            halted_q     <= halted_d;
            timed_out_q  <= timed_out_d;
            prev_pc_q    <= prev_pc_d;
            prev_valid_q <= prev_valid_d;
            rep_q        <= rep_d;
        end
    end

    assign trace_we = (state_q == StRun) && reg_we_i && (reg_waddr_i != 5'd0);

    run_trace_buf #(
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (start_run),
        .we_i       (trace_we),
        .wdata_i    (pack_trace(retire_pc_i, reg_waddr_i, reg_wdata_i)),
        .rd_idx_i   (trace_rd_idx_i),
        .count_o    (trace_count_o),
        .rd_valid_o (trace_rd_valid_o),
        .rd_data_o  (trace_rd_data_o)
    );

    assign core_reset_o = (state_q != StRun);
    assign running_o    = (state_q == StRun);
    assign done_o       = (state_q == StDone);
    assign halted_o     = halted_q;
    assign timed_out_o  = timed_out_q;
    assign cycle_cnt_o  = cycle_q;
    assign retire_cnt_o = retire_q;

endmodule
